pwm_demod: RTL and testbench

PWM_DEMOD -- requirements
Module: pwm_demod

---
 rtl/pwm_pkg.sv | 20 ++
 rtl/pwm_sync.sv | 29 ++
 rtl/pwm_demod.sv | 88 ++++++++
 tb/tb_pwm_demod.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM constants and types.
// Used by the demodulator and the PWM generator.
package pwm_pkg;

  localparam int PWM_PERIOD = 256;
  localparam int PWM_DW     = 8;
  localparam int CNT_W      = 9;

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/pwm_sync.sv
// Input synchronizer for the PWM line.
// Produces the synced level and a rising-edge strobe.
module pwm_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic s,
  output logic rise
);

  logic [STAGES-1:0] sync;
  logic              s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      s_q  <= 1'b0;
    end else begin
      sync <= (sync << 1) | STAGES'(d);
      s_q  <= sync[STAGES-1];
    end
  end

  assign s    = sync[STAGES-1];
  assign rise = s & ~s_q;

endmodule

// File: rtl/pwm_demod.sv
// PWM demodulator: measures high time per frame.
// Long flat runs decode as 0 (low) or 255 + err (high).
module pwm_demod
  import pwm_pkg::*;
#(
  parameter int PERIOD      = PWM_PERIOD,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [PWM_DW-1:0] dout,
  output logic              dout_valid,
  output logic              err
);

  localparam logic [CNT_W-1:0] PER = CNT_W'(PERIOD);

  state_t           state;
  logic             s;
  logic             rise;
  logic             s_d;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] run_len;
  logic             timeout;

  pwm_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pwm_in),
    .s   (s),
    .rise(rise)
  );

  // run_len is the length of the current flat run, this sample included
  always_comb begin
    run_len = (s != s_d) ? CNT_W'(1) : sat_inc(run_cnt);
    timeout = (run_len == PER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      s_d        <= 1'b0;
      period_cnt <= '0;
      high_cnt   <= '0;
      run_cnt    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      s_d        <= s;
      run_cnt    <= timeout ? '0 : run_len;
      dout_valid <= 1'b0;
      err        <= 1'b0;
      if (rise) begin
        period_cnt <= CNT_W'(1);
        high_cnt   <= CNT_W'(1);
        state      <= MEASURE;
        if (state == MEASURE) begin
          if (period_cnt == PER) begin
            dout       <= high_cnt[PWM_DW-1:0];
            dout_valid <= 1'b1;
          end else begin
            err <= 1'b1;
          end
        end
      end else if (timeout) begin
        dout       <= s ? '1 : '0;
        dout_valid <= 1'b1;
        err        <= s;
        state      <= IDLE;
        period_cnt <= '0;
        high_cnt   <= '0;
      end else if (state == MEASURE) begin
        period_cnt <= sat_inc(period_cnt);
        if (s) begin
          high_cnt <= sat_inc(high_cnt);
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_demod.sv
// Bench for pwm_demod: waveform-level scoreboard
// of expected decode events and their cycle.
module tb_pwm_demod;

  localparam int PER = 256;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       pwm_in = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       err;

  pwm_demod #(
    .PERIOD     (PER),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pwm_in    (pwm_in),
    .dout      (dout),
    .dout_valid(dout_valid),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       v;
    logic       e;
  } ev_t;

  typedef struct {
    int         din;
    int         period;
    int         nfr;
    logic [7:0] xd;
    logic       xe;
  } vec_t;

  ev_t        q[$];
  int         cyc       = 0;
  int         checks    = 0;
  int         errors    = 0;
  int         run_start = 0;
  logic       lvl       = 1'b0;
  logic       open      = 1'b0;
  logic       rst_d     = 1'b0;
  logic [7:0] open_xd   = 8'd0;
  logic       open_xe   = 1'b0;
  logic [7:0] last      = 8'd0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= rst;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [7:0] d,
                      input logic v, input logic e);
    ev_t x;
    x.cyc = c;
    x.d   = d;
    x.v   = v;
    x.e   = e;
    q.push_back(x);
  endtask

  // One cycle of stimulus; an event shows 3 cycles after its cause
  task automatic tick(input logic v, input logic r);
    int k;
    @(posedge clk);
    #1;
    pwm_in = v;
    rst    = r;
    k      = cyc;
    if (r) begin
      open      = 1'b0;
      lvl       = 1'b0;
      run_start = k - 1;
      q.delete();
    end else if (v != lvl) begin
      if (v && open) push(k + 3, open_xd, !open_xe, open_xe);
      if (v) open = 1'b1;
      lvl       = v;
      run_start = k;
    end else if ((k - run_start + 1) % PER == 0) begin
      push(k + 3, v ? 8'hFF : 8'h00, 1'b1, v);
      open = 1'b0;
    end
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) tick(v, 1'b0);
  endtask

  task automatic frame(input int din, input int period,
                       input logic [7:0] xd, input logic xe,
                       input int rst_at);
    for (int i = 0; i < period; i++) begin
      tick(i < din, i == rst_at);
      if (i == 0) begin
        open_xd = xd;
        open_xe = xe;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_d) begin
      chk("rst_dout", dout, 0);
      chk("rst_valid", dout_valid, 0);
      chk("rst_err", err, 0);
      last = 8'd0;
    end else begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_event: none at cycle %0d, required v=%0b e=%0b d=%0d",
                 q[0].cyc, q[0].v, q[0].e, q[0].d);
        void'(q.pop_front());
      end
      if (dout_valid || err) begin
        if (q.size() == 0 || q[0].cyc != cyc) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: v=%0b e=%0b d=%0d at cycle %0d, required none",
                   dout_valid, err, dout, cyc);
        end else begin
          ev_t e;
          e = q.pop_front();
          chk("valid", dout_valid, e.v);
          chk("err", err, e.e);
          chk("dout", dout, e.v ? e.d : last);
          if (e.v) last = e.d;
        end
      end
    end
  end

  initial begin
    vec_t tbl[6];
    tbl[0] = '{100, 256, 3, 8'd100, 1'b0};
    tbl[1] = '{1,   256, 2, 8'd1,   1'b0};
    tbl[2] = '{128, 256, 2, 8'd128, 1'b0};
    tbl[3] = '{255, 256, 2, 8'd255, 1'b0};
    tbl[4] = '{50,  200, 1, 8'd0,   1'b1};
    tbl[5] = '{77,  256, 2, 8'd77,  1'b0};

    repeat (3) tick(1'b0, 1'b1);
    // held low from reset: zero decodes every 256 cycles
    hold(1'b0, 600);

    foreach (tbl[i]) begin
      for (int f = 0; f < tbl[i].nfr; f++) begin
        frame(tbl[i].din, tbl[i].period, tbl[i].xd, tbl[i].xe, -1);
      end
    end
    hold(1'b0, 260);

    // stuck high: saturated 255 with err
    hold(1'b1, 300);
    hold(1'b0, 10);

    // mid-frame reset discards the partial frame
    frame(60, 256, 8'd60, 1'b0, -1);
    frame(60, 256, 8'd60, 1'b0, 120);
    repeat (2) frame(60, 256, 8'd60, 1'b0, -1);
    hold(1'b0, 300);
    hold(1'b0, 8);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: %0d left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
